// File: rtl/alu_vect.sv
// Lane-parallel vector ALU: M independent N-bit lanes, one registered op per cycle.
// Build option: define ALUVECT_DIV_EN to include the per-lane dividers (opcode 1111).
module alu_vect #(
  parameter int unsigned N = 24,
  parameter int unsigned M = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*M-1:0] a,
  input  logic [N*M-1:0] b,
  input  logic [3:0]     select,
  output logic [N*M-1:0] result
);

  localparam logic [3:0] OpMov = 4'b1010;
  localparam logic [3:0] OpSin = 4'b1011;
  localparam logic [3:0] OpCos = 4'b1100;
  localparam logic [3:0] OpAdd = 4'b1101;
  localparam logic [3:0] OpMul = 4'b1110;
`ifdef ALUVECT_DIV_EN
  localparam logic [3:0] OpDiv = 4'b1111;
`endif

  // First quarter wave of round(256*sin(2*pi*k/256)), k = 0..64; the rest follows by symmetry.
  localparam logic [8:0] QuarterSin [65] = '{
    9'd0,   9'd6,   9'd13,  9'd19,  9'd25,  9'd31,  9'd38,  9'd44,  9'd50,  9'd56,
    9'd62,  9'd68,  9'd74,  9'd80,  9'd86,  9'd92,  9'd98,  9'd104, 9'd109, 9'd115,
    9'd121, 9'd126, 9'd132, 9'd137, 9'd142, 9'd147, 9'd152, 9'd157, 9'd162, 9'd167,
    9'd172, 9'd177, 9'd181, 9'd185, 9'd190, 9'd194, 9'd198, 9'd202, 9'd206, 9'd209,
    9'd213, 9'd216, 9'd220, 9'd223, 9'd226, 9'd229, 9'd231, 9'd234, 9'd237, 9'd239,
    9'd241, 9'd243, 9'd245, 9'd247, 9'd248, 9'd250, 9'd251, 9'd252, 9'd253, 9'd254,
    9'd255, 9'd255, 9'd256, 9'd256, 9'd256
  };

  function automatic logic [N-1:0] sin_lookup(input logic [7:0] k);
    logic [6:0]   idx;
    logic [N-1:0] mag;
    idx = k[6] ? (7'd64 - {1'b0, k[5:0]}) : {1'b0, k[5:0]};
    mag = {{(N-9){1'b0}}, QuarterSin[idx]};
    return k[7] ? -mag : mag;
  endfunction

  logic [N*M-1:0] result_d, result_q;

  for (genvar i = 0; i < M; i++) begin : g_lane
    logic [N-1:0] a_l, b_l, r_l;

    assign a_l = a[N*i +: N];
    assign b_l = b[N*i +: N];

    always_comb begin
      r_l = '0;
      case (select)
        OpMov:   r_l = b_l;
        OpSin:   r_l = sin_lookup(a_l[7:0]);
        // cos(k) = sin(k + quarter turn); the 8-bit add wraps modulo 256.
        OpCos:   r_l = sin_lookup(a_l[7:0] + 8'd64);
        OpAdd:   r_l = a_l + b_l;
        OpMul:   r_l = a_l * b_l;
`ifdef ALUVECT_DIV_EN
        OpDiv:   r_l = (b_l == '0) ? '1 : (a_l / b_l);
`endif
        default: r_l = '0;
      endcase
    end

    assign result_d[N*i +: N] = r_l;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu_vect.sv
// Self-checking bench for alu_vect: directed cases plus random vectors against a real-math model.
module tb_alu_vect;

  localparam int unsigned N = 24;
  localparam int unsigned M = 6;
  localparam int unsigned W = N * M;
  localparam longint unsigned Mask = 64'hFF_FFFF;
  localparam real Pi = 3.14159265358979323846;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a, b;
  logic [3:0]   select;
  logic [W-1:0] result;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q;

  alu_vect #(.N(N), .M(M)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .select (select),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned trig(input int k, input bit use_cos);
    real v;
    int  r;
    v = 256.0 * (use_cos ? $cos(2.0 * Pi * k / 256.0) : $sin(2.0 * Pi * k / 256.0));
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return longint'(r) & Mask;
  endfunction

  function automatic logic [W-1:0] model(input logic [3:0] sel, input logic [W-1:0] av,
                                         input logic [W-1:0] bv);
    logic [W-1:0] r;
    longint unsigned x, z, y;
    r = '0;
    for (int i = 0; i < M; i++) begin
      x = longint'(av[N*i +: N]);
      z = longint'(bv[N*i +: N]);
      case (sel)
        4'b1010: y = z;
        4'b1011: y = trig(int'(x % 256), 1'b0);
        4'b1100: y = trig(int'(x % 256), 1'b1);
        4'b1101: y = x + z;
        4'b1110: y = x * z;
`ifdef ALUVECT_DIV_EN
        4'b1111: y = (z == 0) ? Mask : x / z;
`endif
        default: y = 0;
      endcase
      r[N*i +: N] = N'(y & Mask);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pack(input logic [23:0] l0, input logic [23:0] l1,
                                        input logic [23:0] l2, input logic [23:0] l3,
                                        input logic [23:0] l4, input logic [23:0] l5);
    return {l5, l4, l3, l2, l1, l0};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive between edges, confirm the output has not moved yet, then check one edge later.
  task automatic step(input string tag, input logic [3:0] sel, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input logic rst);
    @(negedge clk);
    reset  = rst;
    select = sel;
    a      = av;
    b      = bv;
    #1 check({tag, "/hold"}, result, exp_q);
    @(posedge clk);
    #1;
    exp_q = rst ? '0 : model(sel, av, bv);
    check(tag, result, exp_q);
  endtask

  logic [W-1:0] va, vb, vb0, ta, ra, rb;
  logic [3:0]   rsel;

  initial begin
    va  = pack(24'd12, 24'd45, 24'd33, 24'd98, 24'd86, 24'd52);
    vb  = pack(24'd37, 24'd12, 24'd36, 24'd41, 24'd9,  24'd40);
    vb0 = pack(24'd37, 24'd12, 24'd0,  24'd41, 24'd9,  24'd40);
    ta  = pack(24'd0, 24'd64, 24'd128, 24'd192, 24'd256, 24'h234040);

    reset  = 1'b1;
    select = 4'b1101;
    a      = va;
    b      = vb;
    @(posedge clk);
    #1;
    exp_q = '0;
    check("reset", result, exp_q);

    step("post_reset_add", 4'b1101, va, vb, 1'b0);
    check("post_reset_sums", result, pack(24'd49, 24'd57, 24'd69, 24'd139, 24'd95, 24'd92));

    step("mov", 4'b1010, va, vb, 1'b0);
    check("mov_lit", result, vb);
    step("add", 4'b1101, va, vb, 1'b0);
    check("add_lit", result, pack(24'd49, 24'd57, 24'd69, 24'd139, 24'd95, 24'd92));
    step("mult", 4'b1110, va, vb, 1'b0);
    check("mult_lit", result, pack(24'd444, 24'd540, 24'd1188, 24'd4018, 24'd774, 24'd2080));

    step("div", 4'b1111, va, vb, 1'b0);
`ifdef ALUVECT_DIV_EN
    check("div_lit", result, pack(24'd0, 24'd3, 24'd0, 24'd2, 24'd9, 24'd1));
    step("div_by_zero", 4'b1111, va, vb0, 1'b0);
    check("div_by_zero_lit", result, pack(24'd0, 24'd3, 24'hFFFFFF, 24'd2, 24'd9, 24'd1));
`else
    check("div_disabled_lit", result, '0);
    step("div_by_zero", 4'b1111, va, vb0, 1'b0);
    check("div_by_zero_disabled", result, '0);
`endif

    step("add_ovf", 4'b1101, pack(24'hFFFFFF, 24'd7, 24'd100, 24'd0, 24'hFFFFFE, 24'd9),
         pack(24'd1, 24'd3, 24'd200, 24'd5, 24'd1, 24'd11), 1'b0);
    check("add_ovf_lit", result, pack(24'd0, 24'd10, 24'd300, 24'd5, 24'hFFFFFF, 24'd20));
    step("mult_ovf", 4'b1110, pack(24'h001000, 24'd7, 24'd100, 24'd0, 24'hFFFFFF, 24'd9),
         pack(24'h001000, 24'd3, 24'd200, 24'd5, 24'd2, 24'd11), 1'b0);
    check("mult_ovf_lit", result, pack(24'd0, 24'd21, 24'd20000, 24'd0, 24'hFFFFFE, 24'd99));

    step("sin", 4'b1011, ta, vb, 1'b0);
    check("sin_lit", result, pack(24'h0, 24'h100, 24'h0, 24'hFFFF00, 24'h0, 24'h100));
    step("cos", 4'b1100, ta, vb, 1'b0);
    check("cos_lit", result, pack(24'h100, 24'h0, 24'hFFFF00, 24'h0, 24'h100, 24'h0));

    step("seq_add", 4'b1101, vb, va, 1'b0);
    step("seq_mult", 4'b1110, vb, vb, 1'b0);
    step("seq_mov", 4'b1010, vb, va, 1'b0);
    check("seq_mov_lit", result, va);

    step("unused_0101", 4'b0101, va, vb, 1'b0);
    check("unused_lit", result, '0);
    step("reset_wins", 4'b1110, va, vb, 1'b1);
    check("reset_wins_lit", result, '0);

    for (int n = 0; n < 300; n++) begin
      rsel = ($urandom_range(3, 0) != 0) ? 4'($urandom_range(15, 10)) : 4'($urandom_range(15, 0));
      for (int i = 0; i < M; i++) begin
        case ($urandom_range(3, 0))
          0:       begin ra[N*i +: N] = 24'($urandom_range(255, 0)); rb[N*i +: N] = '0; end
          1:       begin ra[N*i +: N] = 24'($urandom); rb[N*i +: N] = 24'($urandom_range(300, 0)); end
          default: begin ra[N*i +: N] = 24'($urandom); rb[N*i +: N] = 24'($urandom); end
        endcase
      end
      step("rand", rsel, ra, rb, ($urandom_range(19, 0) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
